// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
package sp_ram_pkg;

    typedef enum logic [1:0] {
        RD_NO_CHANGE   = 2'd0,
        RD_READ_FIRST  = 2'd1,
        RD_WRITE_FIRST = 2'd2
    } rd_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    // Widest word the merge helper handles; callers zero-extend into it and
    // cast the result back down to their own width.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Byte-lane merge: lanes with be set take the new word, others keep the old.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sp_ram_clear_ctrl.sv
// Clear sequencer: owns the CLEAR/READY FSM, the sweep counter, the ready
// flag and the mux that hands the memory write port to either the sweep or
// the user access.
//
//   state | meaning
//   CLEAR | sweep writes 0 to word cnt each cycle, accesses refused
//   READY | sweep idle, user accesses accepted
module sp_ram_clear_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              acc_we_i,
    input  logic [ADDR_W-1:0] acc_addr_i,
    input  logic [DATA_W-1:0] acc_wdata_i,
    output logic              ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset starts a fresh sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a clear pulse always (re)starts the sweep at word 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (clear_i) begin
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = CLEAR;
            end
        endcase
    end

    // Write port mux: the sweep owns the port for the whole CLEAR state.
    always_comb begin
        mem_we_o    = acc_we_i;
        mem_addr_o  = acc_addr_i;
        mem_wdata_o = acc_wdata_i;
        if (state_q == CLEAR) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = cnt_q;
            mem_wdata_o = '0;
        end
    end

    assign ready_o = (state_q == READY);

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port RAM: byte-write enables, selectable
// read-during-write behaviour, optional output register and a clear sweep
// after reset or on command. Responses come back with an rvalid strobe and
// rdata holds the last returned word between strobes.
module sp_ram_param
    import sp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int RD_MODE = 1,
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                ready_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o
);

    localparam rd_mode_e MODE = rd_mode_e'(RD_MODE[1:0]);

    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $fatal(1, "sp_ram_param: DATA_W must be a multiple of 8 within range");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_bad_depth
        $fatal(1, "sp_ram_param: DEPTH must lie in 1..2**ADDR_W");
    end
    if (RD_MODE < 0 || RD_MODE > 2) begin : g_bad_rd_mode
        $fatal(1, "sp_ram_param: RD_MODE must be 0, 1 or 2");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_out_reg
        $fatal(1, "sp_ram_param: OUT_REG must be 0 or 1");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready;
    logic              accept;
    logic              in_range;
    logic              acc_we;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              s0_valid_d, s0_valid_q;
    logic [DATA_W-1:0] s0_data_d, s0_data_q;
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;

    assign accept   = en_i & ready;
    assign in_range = (32'(addr_i) < DEPTH);
    assign acc_we   = accept & we_i & in_range;

    // Current word at the access address; out-of-range addresses read as 0.
    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem_q[addr_i];
        end
    end

    assign merged_word = DATA_W'(be_merge(MAX_DATA_W'(old_word),
                                          MAX_DATA_W'(wdata_i),
                                          MAX_BE_W'(be_i)));

    sp_ram_clear_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_i),
        .acc_we_i    (acc_we),
        .acc_addr_i  (addr_i),
        .acc_wdata_i (merged_word),
        .ready_o     (ready),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata)
    );

    // Storage array; contents are initialised by the clear sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    // Response selection: reads always answer, writes answer per RD_MODE.
    always_comb begin
        s0_valid_d = 1'b0;
        s0_data_d  = old_word;
        if (accept) begin
            if (!we_i) begin
                s0_valid_d = 1'b1;
            end else begin
                case (MODE)
                    RD_READ_FIRST: begin
                        s0_valid_d = 1'b1;
                    end
                    RD_WRITE_FIRST: begin
                        s0_valid_d = 1'b1;
                        s0_data_d  = in_range ? merged_word : '0;
                    end
                    default: begin
                        s0_valid_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Synchronous read stage and output holding stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            if (s0_valid_d) begin
                s0_data_q <= s0_data_d;
            end
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_data_q <= s0_data_q;
            end
        end
    end

    if (OUT_REG == 1) begin : g_out_reg
        logic              s2_valid_q;
        logic [DATA_W-1:0] s2_data_q;

        // Extra output pipeline stage, holding its data between strobes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rvalid_o = s2_valid_q;
        assign rdata_o  = s2_data_q;
    end else begin : g_no_out_reg
        assign rvalid_o = s1_valid_q;
        assign rdata_o  = s1_data_q;
    end

    assign ready_o = ready;

endmodule

// File: tb/tb_sp_ram_param.sv
// Scoreboard bench for sp_ram_param: five instances (READ_FIRST, WRITE_FIRST,
// NO_CHANGE, READ_FIRST with output register, and a 12-word READ_FIRST)
// driven with directed vectors whose expected responses are queued with the
// cycle they are due on.
module tb_sp_ram_param;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b, clear_a, clear_b, we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wdata;

    logic        rdy [5];
    logic        rv  [5];
    logic [31:0] rd  [5];

    exp_t sb_q [5][$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_MODE(1), .OUT_REG(0)) u_rf (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_a), .en_i(en_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .ready_o(rdy[0]), .rdata_o(rd[0]), .rvalid_o(rv[0]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_MODE(2), .OUT_REG(0)) u_wf (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_a), .en_i(en_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .ready_o(rdy[1]), .rdata_o(rd[1]), .rvalid_o(rv[1]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_MODE(0), .OUT_REG(0)) u_nc (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_a), .en_i(en_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .ready_o(rdy[2]), .rdata_o(rd[2]), .rvalid_o(rv[2]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_MODE(1), .OUT_REG(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_a), .en_i(en_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .ready_o(rdy[3]), .rdata_o(rd[3]), .rvalid_o(rv[3]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_MODE(1), .OUT_REG(0)) u_small (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_b), .en_i(en_b), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .ready_o(rdy[4]), .rdata_o(rd[4]), .rvalid_o(rv[4]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid pops the oldest expectation of that instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 5; i++) begin
                if (rv[i] === 1'b1) begin
                    checks++;
                    if (sb_q[i].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rvalid dut%0d actual rdata=%h cyc=%0d required no response",
                                 i, rd[i], cyc);
                    end else begin
                        exp_t e;
                        e = sb_q[i].pop_front();
                        if (rd[i] !== e.data || cyc != e.due) begin
                            failures++;
                            $display("FAIL sb_dut%0d actual data=%h cyc=%0d required data=%h cyc=%0d",
                                     i, rd[i], cyc, e.data, e.due);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int idx, input logic [31:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        sb_q[idx].push_back(e);
    endtask

    // One access in the next cycle; exp_old/exp_new are the word before/after it.
    task automatic acc(input bit grp_b, input bit wr, input logic [3:0] b, input logic [3:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_old,
                       input logic [31:0] exp_new, input bit clr);
        int due;
        @(negedge clk);
        we      = wr;
        be      = b;
        addr    = a;
        wdata   = wd;
        en_a    = !grp_b;
        en_b    = grp_b;
        clear_a = clr && !grp_b;
        clear_b = clr && grp_b;
        due     = cyc + 2;
        if (!grp_b) begin
            push(0, exp_old, due);
            push(1, wr ? exp_new : exp_old, due);
            if (!wr) push(2, exp_old, due);
            push(3, exp_old, due + 1);
        end else begin
            push(4, exp_old, due);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        clear_a = 1'b0;
        clear_b = 1'b0;
        we = 1'b0;
    endtask

    task automatic ready_ramp(input string tag);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk({tag, "_ready_a"}, 32'(rdy[0]), 32'(k >= 16));
            chk({tag, "_ready_b"}, 32'(rdy[4]), 32'(k >= 12));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_ready%0d", tag, i), 32'(rdy[i]), 32'd0);
            chk($sformatf("%s_rvalid%0d", tag, i), 32'(rv[i]), 32'd0);
            chk($sformatf("%s_rdata%0d", tag, i), rd[i], 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] olds [8];
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
        we = 1'b0; be = '0; addr = '0; wdata = '0;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        ready_ramp("ramp1");

        for (int a = 0; a < 16; a++) acc(0, 0, 4'h0, 4'(a), 32'h0, 32'h0, 32'h0, 0);

        acc(0, 1, 4'b1111, 4'd3, 32'hAABBCCDD, 32'h00000000, 32'hAABBCCDD, 0);
        acc(0, 1, 4'b0101, 4'd3, 32'h11223344, 32'hAABBCCDD, 32'hAA22CC44, 0);
        acc(0, 0, 4'h0,    4'd3, 32'h0,        32'hAA22CC44, 32'h0,        0);

        acc(0, 1, 4'b1111, 4'd5, 32'h12345678, 32'h00000000, 32'h12345678, 0);
        acc(0, 1, 4'b0011, 4'd5, 32'hFFFFFFFF, 32'h12345678, 32'h1234FFFF, 0);
        idle();
        repeat (3) @(negedge clk);
        chk("nc_rdata_hold", rd[2], 32'hAA22CC44);
        acc(0, 0, 4'h0,    4'd5, 32'h0,        32'h1234FFFF, 32'h0,        0);
        acc(0, 1, 4'b0000, 4'd5, 32'h0,        32'h1234FFFF, 32'h1234FFFF, 0);
        acc(0, 0, 4'h0,    4'd5, 32'h0,        32'h1234FFFF, 32'h0,        0);
        acc(0, 1, 4'b1111, 4'd9, 32'h5A5A5A5A, 32'h00000000, 32'h5A5A5A5A, 0);
        acc(0, 0, 4'h0,    4'd9, 32'h0,        32'h5A5A5A5A, 32'h0,        0);

        olds = '{32'h0, 32'h0, 32'h0, 32'hAA22CC44, 32'h0, 32'h1234FFFF, 32'h0, 32'h0};
        for (int a = 0; a < 8; a++)
            acc(0, 1, 4'b1111, 4'(a), 32'hC0DE0000 + 32'(a), olds[a], 32'hC0DE0000 + 32'(a), 0);
        for (int a = 0; a < 8; a++)
            acc(0, 0, 4'h0, 4'(a), 32'h0, 32'hC0DE0000 + 32'(a), 32'h0, 0);

        acc(0, 0, 4'h0, 4'd1, 32'h0, 32'hC0DE0001, 32'h0, 1);
        idle();
        chk("clr_ready_k0", 32'(rdy[0]), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("clr_ready_a", 32'(rdy[0]), 32'(k == 16));
        end
        chk("clr_done_hold_rf", rd[0], 32'hC0DE0001);
        chk("clr_done_hold_pipe", rd[3], 32'hC0DE0001);
        acc(0, 0, 4'h0, 4'd1, 32'h0, 32'h0, 32'h0, 0);
        acc(0, 0, 4'h0, 4'd3, 32'h0, 32'h0, 32'h0, 0);

        acc(1, 1, 4'b1111, 4'd13, 32'hDEADBEEF, 32'h0, 32'h0, 0);
        acc(1, 0, 4'h0,    4'd13, 32'h0,        32'h0, 32'h0, 0);
        acc(1, 0, 4'h0,    4'd1,  32'h0,        32'h0, 32'h0, 0);
        acc(1, 1, 4'b1111, 4'd2,  32'h22222222, 32'h0, 32'h22222222, 0);
        acc(1, 0, 4'h0,    4'd2,  32'h0,        32'h22222222, 32'h0, 0);
        acc(1, 1, 4'b1111, 4'd2,  32'h33333333, 32'h22222222, 32'h33333333, 1);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            chk("clr_ready_b", 32'(rdy[4]), 32'(k == 12));
            clear_b = 1'b0;
            we      = 1'b1;
            be      = 4'b1111;
            addr    = 4'd0;
            wdata   = 32'h77777777;
            en_b    = (k < 12);
        end
        acc(1, 0, 4'h0, 4'd0, 32'h0, 32'h0, 32'h0, 0);
        acc(1, 0, 4'h0, 4'd2, 32'h0, 32'h0, 32'h0, 0);

        acc(0, 1, 4'b1111, 4'd4, 32'h0BADF00D, 32'h0, 32'h0BADF00D, 0);
        acc(0, 0, 4'h0,    4'd4, 32'h0,        32'h0BADF00D, 32'h0, 1);
        idle();
        repeat (7) @(posedge clk);
        #1;
        chk("sweep_rdata_hold", rd[0], 32'h0BADF00D);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ready_ramp("ramp2");
        acc(0, 0, 4'h0, 4'd4, 32'h0, 32'h0, 32'h0, 0);
        acc(1, 0, 4'h0, 4'd2, 32'h0, 32'h0, 32'h0, 0);
        idle();

        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++)
            chk($sformatf("sb_drain%0d", i), 32'(sb_q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_ram_param.md
# sp_ram_param

Parametrised single-port synchronous RAM with byte-write enables, selectable read-during-write mode, optional output pipeline register and a hardware clear sequencer that zeroes every word after reset or on command. It is the general-purpose on-chip storage primitive for scratchpads, lookup tables and packet buffers, and replaces fixed 8-bit/32-entry RAM instances. Accesses are accepted one per cycle once `ready` is high, and read data returns with a `rvalid` strobe.

## Interface
- `DATA_W`, 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, 6: address width.
- `DEPTH`, 2**ADDR_W: number of words; 1 ≤ DEPTH ≤ 2**ADDR_W.
- `RD_MODE`, 1: read-during-write behaviour.
  - 0: NO_CHANGE.
  - 1: READ_FIRST.
  - 2: WRITE_FIRST.
- `OUT_REG`, 0: 1 adds one output pipeline stage.
- `clk` input 1: clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: single-cycle pulse; starts a clear sweep.
- `en` input 1: access request.
- `we` input 1: 1 means write, 0 means read.
- `be` input DATA_W/8: byte-write enables; bit i covers `wdata[8i+7:8i]`.
- `addr` input ADDR_W: word address.
- `wdata` input DATA_W: write data.
- `ready` output 1: high when accesses are accepted.
- `rdata` output DATA_W: read data.
- `rvalid` output 1: one-cycle strobe qualifying `rdata`.

## Operation
- The FSM has two states: CLEAR and READY.
  - Reset enters CLEAR with the sweep counter at 0.
  - CLEAR writes 0 to word `cnt` each cycle, incrementing `cnt` from 0 to DEPTH-1, then moves to READY.
  - `clear` sampled high in READY enters CLEAR with `cnt`=0.
  - `clear` sampled high in CLEAR restarts the sweep at 0.
- `ready` is 1 only in READY. An access is accepted when `en & ready`. With `ready`=0, `en` is ignored, has no side effects and is not queued.
- Write (`we`=1): byte i of `mem[addr]` is updated only where `be[i]`=1. `be`=0 is a legal no-op write.
- Read (`we`=0): returns `mem[addr]`; `rvalid` pulses.
- Write response by `RD_MODE`:
  - 0 (NO_CHANGE): no `rvalid`; `rdata` holds its previous value.
  - 1 (READ_FIRST): `rvalid` pulses with the pre-write word.
  - 2 (WRITE_FIRST): `rvalid` pulses with the post-write word, i.e. the byte-merged value.
- Out-of-range address (`addr` ≥ DEPTH): writes are dropped; reads and write responses return 0 with `rvalid` as normal.
- Between `rvalid` pulses, `rdata` holds the last returned value. It is never tri-stated.
- Clear completion does not pulse `rvalid` and does not change `rdata`.
- Reset mid-operation: an in-flight read is discarded (`rvalid`=0) and the sweep restarts from 0.

## Timing
- Reset values: `ready`=0, `rvalid`=0, `rdata`=0. Pipeline-stage valid bits are 0.
- Clear duration:
  - After `rst_n` deasserts, `ready` rises after exactly DEPTH rising edges.
  - After a `clear` pulse in READY, `ready` drops on the next cycle and returns DEPTH cycles later.
- Read latency:
  - OUT_REG=0: access accepted at edge N gives `rvalid`/`rdata` valid after edge N+1.
  - OUT_REG=1: valid after edge N+2.
- Throughput is one access per cycle. Back-to-back read-after-write to the same address returns the new data.
- If `clear` and an accepted access coincide, the access completes (write lands, read returns) and then the clear sweep overwrites the memory.
- An accepted read whose response is still in the pipeline when `clear` arrives still delivers `rvalid`.

## Structure
- Package `sp_ram_pkg` holds:
  - `rd_mode_e` enum: RD_NO_CHANGE=0, RD_READ_FIRST=1, RD_WRITE_FIRST=2.
  - `ram_state_e` enum: CLEAR, READY.
  - A `be_merge` function: old word, new word and `be` in, merged word out.
- Sub-module `sp_ram_clear_ctrl` contains the FSM, sweep counter, `ready` and the clear write port mux.
- The top level holds the memory array, byte merge, read mode selection and output pipeline.
- Elaboration-time assertions cover `DATA_W%8==0`, `DEPTH` range and `RD_MODE`≤2.

## Test plan
- Clear after reset: DATA_W=32, DEPTH=16; deassert `rst_n`.
  - `ready`=0 for 16 cycles, then 1.
  - Reads of all addresses return 0x00000000.
- Byte-enable merge: write 0xAABBCCDD to addr 3 with `be`=4'b1111, then 0x11223344 with `be`=4'b0101.
  - A read of addr 3 returns 0xAA22CC44 one cycle later (OUT_REG=0).
- Read-during-write: mem[5]=0x12345678; write 0xFFFFFFFF with `be`=4'b0011.
  - RD_MODE=1: returns 0x12345678.
  - RD_MODE=2: returns 0x1234FFFF.
  - RD_MODE=0: no `rvalid`.
- Pipelined streaming: OUT_REG=1; reads of addr 0..7 on consecutive cycles.
  - `rvalid` stays high for 8 consecutive cycles, starting 2 cycles after the first accept.
  - Data is returned in order.
- Clear and out-of-range: DEPTH=12, ADDR_W=4.
  - A write to addr 13 is dropped; a read of addr 13 returns 0.
  - A `clear` pulse coinciding with a write to addr 2 is followed by `ready`=0 for 12 cycles; addr 2 then reads 0.
  - `en` during the clear is ignored.
- Async reset mid-sweep: assert `rst_n`=0 at sweep count 7.
  - Outputs go to their reset values immediately.
  - After release, the sweep restarts and `ready` rises DEPTH cycles later.
